// File: rtl/rf_pkg.sv
// Shared constants and FSM state encoding for the register-file access arbiter.
package rf_pkg;

  localparam int RF_ADDR_W       = 5;
  localparam int RF_DATA_W       = 32;
  localparam int RF_STARVE_LIMIT = 4;

  // Arbiter states; core_stall is decoded directly from this register.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_WAIT  = 3'd1,
    WR_STALL = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DATA  = 3'd4,
    RSP      = 3'd5
  } state_t;

endpackage

// File: rtl/regfile_access_arbiter.sv
// Shares the 32x32 register file between the core pipeline and the host debug
// channel. The core owns the ports by default; host writes slip into idle
// write-port cycles (or force a one-cycle stall after starvation), host reads
// freeze the core for two cycles while port A is borrowed.
module regfile_access_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W       = RF_ADDR_W,
  parameter int DATA_W       = RF_DATA_W,
  parameter int STARVE_LIMIT = RF_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_wr_en,
  input  logic [ADDR_W-1:0] core_wr_addr,
  input  logic [DATA_W-1:0] core_wr_data,
  input  logic [ADDR_W-1:0] core_rd_addr_a,
  input  logic [ADDR_W-1:0] core_rd_addr_b,
  output logic              core_stall,
  input  logic              host_req_valid,
  output logic              host_req_ready,
  input  logic              host_req_we,
  input  logic [ADDR_W-1:0] host_req_addr,
  input  logic [DATA_W-1:0] host_req_data,
  output logic              host_rsp_valid,
  output logic [DATA_W-1:0] host_rsp_data,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [ADDR_W-1:0] rf_rd_addr_a,
  output logic [ADDR_W-1:0] rf_rd_addr_b,
  input  logic [DATA_W-1:0] rf_rd_data_a
);

  // Counter is one bit wider than needed for LIMIT-1 so it can never wrap.
  localparam int CNT_W = $clog2(STARVE_LIMIT) + 1;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    starve_cnt_reg;
  logic                req_we_reg;
  logic [ADDR_W-1:0]   req_addr_reg;
  logic [DATA_W-1:0]   req_data_reg;
  logic [DATA_W-1:0]   rsp_data_reg;
  logic                starved;

  assign starved = (starve_cnt_reg == CNT_W'(STARVE_LIMIT - 1));

  // State register, request capture, starvation counter and response data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= '0;
      req_we_reg     <= 1'b0;
      req_addr_reg   <= '0;
      req_data_reg   <= '0;
      rsp_data_reg   <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (host_req_valid) begin
            req_we_reg     <= host_req_we;
            req_addr_reg   <= host_req_addr;
            req_data_reg   <= host_req_data;
            starve_cnt_reg <= '0;
            rsp_data_reg   <= '0;
          end
        end
        WR_WAIT: begin
          if (core_wr_en) begin
            starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
          end
        end
        RD_DATA: begin
          rsp_data_reg <= req_we_reg ? '0 : rf_rd_data_a;
        end
        default: ;
      endcase
    end
  end

  // Next-state and port steering; the core owns every port unless overridden.
  always_comb begin
    state_next     = state_reg;
    host_req_ready = 1'b0;
    rf_write       = core_wr_en;
    rf_wr_addr     = core_wr_addr;
    rf_wr_data     = core_wr_data;
    rf_rd_addr_a   = core_rd_addr_a;
    case (state_reg)
      IDLE: begin
        host_req_ready = 1'b1;
        if (host_req_valid) begin
          state_next = host_req_we ? WR_WAIT : RD_ISSUE;
        end
      end
      WR_WAIT: begin
        if (!core_wr_en) begin
          rf_write   = 1'b1;
          rf_wr_addr = req_addr_reg;
          rf_wr_data = req_data_reg;
          state_next = RSP;
        end else if (starved) begin
          state_next = WR_STALL;
        end
      end
      WR_STALL: begin
        // Core is stalled and holds its own write for the next cycle.
        rf_write   = 1'b1;
        rf_wr_addr = req_addr_reg;
        rf_wr_data = req_data_reg;
        state_next = RSP;
      end
      RD_ISSUE: begin
        rf_write     = 1'b0;
        rf_rd_addr_a = req_addr_reg;
        state_next   = RD_DATA;
      end
      RD_DATA: begin
        // Port A goes back to the core so its data is valid again in RSP.
        rf_write   = 1'b0;
        state_next = RSP;
      end
      RSP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign core_stall     = (state_reg == WR_STALL) || (state_reg == RD_ISSUE) ||
                          (state_reg == RD_DATA);
  assign host_rsp_valid = (state_reg == RSP);
  assign host_rsp_data  = rsp_data_reg;
  assign rf_rd_addr_b   = core_rd_addr_b;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Bench for regfile_access_arbiter: a behavioural register file sits on the rf_*
// ports, directed stimulus pushes expected host responses into a queue and a
// monitor pops and compares them whenever host_rsp_valid is seen.
module tb_regfile_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_wr_en;
  logic [4:0]  core_wr_addr;
  logic [31:0] core_wr_data;
  logic [4:0]  core_rd_addr_a;
  logic [4:0]  core_rd_addr_b;
  logic        core_stall;
  logic        host_req_valid;
  logic        host_req_ready;
  logic        host_req_we;
  logic [4:0]  host_req_addr;
  logic [31:0] host_req_data;
  logic        host_rsp_valid;
  logic [31:0] host_rsp_data;
  logic        rf_write;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [4:0]  rf_rd_addr_a;
  logic [4:0]  rf_rd_addr_b;
  logic [31:0] rf_rd_data_a;
  logic [31:0] rf_rd_data_b;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] mem [32];

  regfile_access_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .core_wr_en     (core_wr_en),
    .core_wr_addr   (core_wr_addr),
    .core_wr_data   (core_wr_data),
    .core_rd_addr_a (core_rd_addr_a),
    .core_rd_addr_b (core_rd_addr_b),
    .core_stall     (core_stall),
    .host_req_valid (host_req_valid),
    .host_req_ready (host_req_ready),
    .host_req_we    (host_req_we),
    .host_req_addr  (host_req_addr),
    .host_req_data  (host_req_data),
    .host_rsp_valid (host_rsp_valid),
    .host_rsp_data  (host_rsp_data),
    .rf_write       (rf_write),
    .rf_wr_addr     (rf_wr_addr),
    .rf_wr_data     (rf_wr_data),
    .rf_rd_addr_a   (rf_rd_addr_a),
    .rf_rd_addr_b   (rf_rd_addr_b),
    .rf_rd_data_a   (rf_rd_data_a)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural register file: x0 writes dropped, 1-cycle registered reads.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
  end
  always @(posedge clk) begin
    if (rf_write && rf_wr_addr != 5'd0) mem[rf_wr_addr] <= rf_wr_data;
    rf_rd_data_a <= (rf_rd_addr_a == 5'd0) ? 32'h0 : mem[rf_rd_addr_a];
    rf_rd_data_b <= (rf_rd_addr_b == 5'd0) ? 32'h0 : mem[rf_rd_addr_b];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor: every pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (host_rsp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rsp_unexpected: got data=0x%08h expected no response (cycle %0d)",
                 host_rsp_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        $display("rsp cycle=%0d data=0x%08h (expected cycle=%0d data=0x%08h)",
                 cyc, host_rsp_data, e.cyc, e.data);
        chk("rsp_data", host_rsp_data, e.data);
        chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] data, input int lat);
    exp_t e;
    e.data = data;
    e.cyc  = cyc + lat;
    exp_q.push_back(e);
  endtask

  // Issue one host request from IDLE with the core idle; returns in the IDLE
  // cycle following the response.
  task automatic host_txn(input logic we, input logic [4:0] addr, input logic [31:0] data,
                          input logic [31:0] exp, input int lat);
    host_req_valid = 1'b1;
    host_req_we    = we;
    host_req_addr  = addr;
    host_req_data  = data;
    at_sample();
    chk("txn_ready", 32'(host_req_ready), 32'd1);
    push_exp(exp, lat);
    next_cycle();
    host_req_valid = 1'b0;
    repeat (lat) next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    core_wr_en     = 1'b0;
    core_wr_addr   = 5'd0;
    core_wr_data   = 32'h0;
    core_rd_addr_a = 5'd0;
    core_rd_addr_b = 5'd0;
    host_req_valid = 1'b0;
    host_req_we    = 1'b0;
    host_req_addr  = 5'd0;
    host_req_data  = 32'h0;

    // Reset state
    next_cycle();
    next_cycle();
    at_sample();
    chk("rst_stall", 32'(core_stall), 32'd0);
    chk("rst_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("rst_rsp_data", host_rsp_data, 32'h0);
    chk("rst_ready", 32'(host_req_ready), 32'd1);
    next_cycle();
    reset = 1'b0;

    // Core writes x7 = DEADBEEF
    core_wr_en = 1'b1; core_wr_addr = 5'd7; core_wr_data = 32'hDEADBEEF;
    at_sample();
    chk("core_wr_pass", 32'(rf_write), 32'd1);
    chk("core_wr_addr", 32'(rf_wr_addr), 32'd7);
    chk("core_wr_data", rf_wr_data, 32'hDEADBEEF);
    next_cycle();
    core_wr_en = 1'b0;

    // Host read x7 while core tries to write x10 during the stall
    $display("txn: host read x7");
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 5'd7;
    core_rd_addr_a = 5'd1;
    at_sample();
    chk("rd_ready", 32'(host_req_ready), 32'd1);
    chk("rd_c0_stall", 32'(core_stall), 32'd0);
    push_exp(32'hDEADBEEF, 3);
    next_cycle();
    host_req_valid = 1'b0;
    core_wr_en = 1'b1; core_wr_addr = 5'd10; core_wr_data = 32'h00000A0A;
    at_sample();
    chk("rd_c1_stall", 32'(core_stall), 32'd1);
    chk("rd_c1_addr_a", 32'(rf_rd_addr_a), 32'd7);
    chk("rd_c1_no_write", 32'(rf_write), 32'd0);
    next_cycle();
    at_sample();
    chk("rd_c2_stall", 32'(core_stall), 32'd1);
    chk("rd_c2_no_write", 32'(rf_write), 32'd0);
    chk("rd_c2_addr_a", 32'(rf_rd_addr_a), 32'd1);
    next_cycle();
    at_sample();
    chk("rd_c3_stall", 32'(core_stall), 32'd0);
    chk("rd_c3_ready", 32'(host_req_ready), 32'd0);
    chk("rd_c3_core_write", 32'(rf_write), 32'd1);
    next_cycle();
    core_wr_en = 1'b0;
    at_sample();
    chk("rd_done_ready", 32'(host_req_ready), 32'd1);
    next_cycle();

    // Host write x3 with idle core
    $display("txn: host write x3");
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 5'd3;
    host_req_data = 32'h12345678;
    at_sample();
    push_exp(32'h0, 2);
    next_cycle();
    host_req_valid = 1'b0;
    at_sample();
    chk("wr_c1_write", 32'(rf_write), 32'd1);
    chk("wr_c1_addr", 32'(rf_wr_addr), 32'd3);
    chk("wr_c1_data", rf_wr_data, 32'h12345678);
    chk("wr_c1_stall", 32'(core_stall), 32'd0);
    next_cycle();
    at_sample();
    chk("wr_c2_stall", 32'(core_stall), 32'd0);
    next_cycle();

    // Host write x4 while the core writes x9 every cycle
    $display("txn: host write x4 under core write pressure");
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 5'd4;
    host_req_data = 32'hA5A5A5A5;
    core_wr_en = 1'b1; core_wr_addr = 5'd9; core_wr_data = 32'h900;
    at_sample();
    push_exp(32'h0, 6);
    chk("st_c0_core_write", 32'(rf_write), 32'd1);
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      host_req_valid = 1'b0;
      core_wr_data = 32'h900 + 32'(i);
      at_sample();
      chk("st_wait_stall", 32'(core_stall), 32'd0);
      chk("st_wait_addr", 32'(rf_wr_addr), 32'd9);
      chk("st_wait_data", rf_wr_data, 32'h900 + 32'(i));
    end
    next_cycle();
    at_sample();
    chk("st_stall", 32'(core_stall), 32'd1);
    chk("st_host_write", 32'(rf_write), 32'd1);
    chk("st_host_addr", 32'(rf_wr_addr), 32'd4);
    chk("st_host_data", rf_wr_data, 32'hA5A5A5A5);
    next_cycle();
    at_sample();
    chk("st_rsp_stall", 32'(core_stall), 32'd0);
    chk("st_resume_addr", 32'(rf_wr_addr), 32'd9);
    chk("st_resume_data", rf_wr_data, 32'h904);
    next_cycle();
    core_wr_en = 1'b0;

    // Back-to-back: write x0 then read x0 with valid held high
    $display("txn: host write x0 then read x0");
    host_req_valid = 1'b1; host_req_we = 1'b1; host_req_addr = 5'd0;
    host_req_data = 32'hFFFFFFFF;
    at_sample();
    chk("x0_wr_ready", 32'(host_req_ready), 32'd1);
    push_exp(32'h0, 2);
    next_cycle();
    host_req_we = 1'b0;
    at_sample();
    chk("x0_wr_write", 32'(rf_write), 32'd1);
    chk("x0_wr_addr", 32'(rf_wr_addr), 32'd0);
    chk("b2b_c1_ready", 32'(host_req_ready), 32'd0);
    next_cycle();
    at_sample();
    chk("b2b_c2_ready", 32'(host_req_ready), 32'd0);
    next_cycle();
    at_sample();
    chk("b2b_c3_ready", 32'(host_req_ready), 32'd1);
    push_exp(32'h0, 3);
    next_cycle();
    host_req_valid = 1'b0;
    repeat (3) next_cycle();

    // Read back what the starvation test wrote
    $display("txn: host read x4");
    host_txn(1'b0, 5'd4, 32'h0, 32'hA5A5A5A5, 3);
    $display("txn: host read x9");
    host_txn(1'b0, 5'd9, 32'h0, 32'h904, 3);

    // Reset during RD_DATA aborts the read without a response
    $display("txn: host read x7 aborted by reset");
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 5'd7;
    at_sample();
    chk("abort_ready", 32'(host_req_ready), 32'd1);
    next_cycle();
    host_req_valid = 1'b0;
    next_cycle();
    reset = 1'b1;
    at_sample();
    chk("abort_rd_data_stall", 32'(core_stall), 32'd1);
    next_cycle();
    reset = 1'b0;
    at_sample();
    chk("abort_stall", 32'(core_stall), 32'd0);
    chk("abort_rsp_valid", 32'(host_rsp_valid), 32'd0);
    chk("abort_ready_idle", 32'(host_req_ready), 32'd1);
    next_cycle();
    at_sample();
    chk("abort_rsp_valid2", 32'(host_rsp_valid), 32'd0);
    next_cycle();
    $display("txn: host read x3 after reset");
    host_txn(1'b0, 5'd3, 32'h0, 32'h12345678, 3);

    // Host read x5 while the core reads x5 on A and x6 on B
    core_wr_en = 1'b1; core_wr_addr = 5'd5; core_wr_data = 32'h55;
    next_cycle();
    core_wr_addr = 5'd6; core_wr_data = 32'h66;
    next_cycle();
    core_wr_en = 1'b0;
    core_rd_addr_a = 5'd5; core_rd_addr_b = 5'd6;
    $display("txn: host read x5 with core reading x5/x6");
    host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 5'd5;
    at_sample();
    chk("pb_c0_addr_b", 32'(rf_rd_addr_b), 32'd6);
    push_exp(32'h55, 3);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      host_req_valid = 1'b0;
      at_sample();
      chk("pb_addr_b", 32'(rf_rd_addr_b), 32'd6);
      if (c == 3) begin
        chk("pb_rsp_core_a", rf_rd_data_a, 32'h55);
        chk("pb_rsp_core_b", rf_rd_data_b, 32'h66);
        chk("pb_rsp_stall", 32'(core_stall), 32'd0);
      end
    end
    next_cycle();

    // Every expected response must have been observed
    repeat (3) next_cycle();
    chk("rsp_pending", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
